// File: rtl/znd_sync_cfg.sv
// znd_sync_cfg: master sync generator and double-buffered configuration for the
// sounding-pulse block. Host writes go to shadow registers. A pending commit copies
// shadow to active on the edge that drives msync_n low, so one sounding cycle
// always sees one consistent configuration.
module znd_sync_cfg #(
    parameter logic [23:0] DEF_PERIOD = 24'd20000,
    parameter logic [7:0]  DEF_ORDER  = 8'hE4
) (
    input  logic        clk20,
    input  logic        res_n,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  rd_addr,
    output logic [31:0] rd_data,
    input  logic        ext_sync_n,
    output logic        msync_n,
    output logic [31:0] frq_div,
    output logic [31:0] pulse_w,
    output logic [31:0] diag_data,
    output logic [23:0] znd_delay0,
    output logic [23:0] znd_delay1,
    output logic [23:0] znd_delay2,
    output logic [23:0] znd_delay3,
    output logic [7:0]  num_order,
    output logic        commit_pend
);

    // control state
    logic        r_run;
    logic        r_ext_mode;
    logic        r_commit_pend;

    // shadow configuration (host side)
    logic [23:0] r_sh_period;
    logic [31:0] r_sh_frq;
    logic [31:0] r_sh_pw;
    logic [31:0] r_sh_diag;
    logic [23:0] r_sh_dly [4];
    logic [7:0]  r_sh_order;

    // active configuration (consumer side)
    logic [23:0] r_act_period;
    logic [31:0] r_act_frq;
    logic [31:0] r_act_pw;
    logic [31:0] r_act_diag;
    logic [23:0] r_act_dly [4];
    logic [7:0]  r_act_order;

    // sync generation
    logic [23:0] r_cnt;
    logic        r_msync_n;
    logic [15:0] r_sync_cnt;
    logic        r_ext_s1;
    logic        r_ext_s2;
    logic        r_ext_s2_d;
    logic        r_ext_fall;
    logic [31:0] r_rd_data;

    logic        w_wr_ctrl;
    logic        w_int_mode;
    logic        w_ext_run;
    logic        w_pulse;
    logic        w_copy;
    logic        w_ext_fall;
    logic [23:0] w_p_eff;
    logic [23:0] w_p_last;
    logic [31:0] w_rd_mux;

    assign w_wr_ctrl  = wr_en && (wr_addr == 4'd0);
    assign w_int_mode = r_run && !r_ext_mode;
    assign w_ext_run  = r_run && r_ext_mode;
    // A pulse is the edge that drives msync_n low; the copy rides on it.
    assign w_pulse    = (w_int_mode && (r_cnt == 24'd0)) || (w_ext_run && r_ext_fall);
    assign w_copy     = w_pulse && r_commit_pend;
    assign w_ext_fall = r_ext_s2_d && !r_ext_s2;
    assign w_p_last   = w_p_eff - 24'd1;

    // Effective period: PERIOD values below 2 are clamped to 2.
    always_comb begin
        w_p_eff = r_act_period;
        if (r_act_period < 24'd2) begin
            w_p_eff = 24'd2;
        end else begin
            w_p_eff = r_act_period;
        end
    end

    // CTRL register and commit request; a commit write on a pulse edge waits for the next pulse.
    always_ff @(posedge clk20 or negedge res_n) begin
        if (!res_n) begin
            r_run         <= 1'b0;
            r_ext_mode    <= 1'b0;
            r_commit_pend <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_run      <= wr_data[0];
                r_ext_mode <= wr_data[1];
            end
            if (w_wr_ctrl && wr_data[2]) begin
                r_commit_pend <= 1'b1;
            end else if (w_copy) begin
                r_commit_pend <= 1'b0;
            end
        end
    end

    // Shadow register writes from the host.
    always_ff @(posedge clk20 or negedge res_n) begin
        if (!res_n) begin
            r_sh_period <= DEF_PERIOD;
            r_sh_frq    <= 32'd0;
            r_sh_pw     <= 32'd0;
            r_sh_diag   <= 32'd0;
            r_sh_dly[0] <= 24'd0;
            r_sh_dly[1] <= 24'd0;
            r_sh_dly[2] <= 24'd0;
            r_sh_dly[3] <= 24'd0;
            r_sh_order  <= DEF_ORDER;
        end else if (wr_en) begin
            case (wr_addr)
                4'd1:    r_sh_period <= wr_data[23:0];
                4'd2:    r_sh_frq    <= wr_data;
                4'd3:    r_sh_pw     <= wr_data;
                4'd4:    r_sh_diag   <= wr_data;
                4'd5:    r_sh_dly[0] <= wr_data[23:0];
                4'd6:    r_sh_dly[1] <= wr_data[23:0];
                4'd7:    r_sh_dly[2] <= wr_data[23:0];
                4'd8:    r_sh_dly[3] <= wr_data[23:0];
                4'd9:    r_sh_order  <= wr_data[7:0];
                default: ;
            endcase
        end
    end

    // Active configuration takes the pre-write shadow values on a committed pulse.
    always_ff @(posedge clk20 or negedge res_n) begin
        if (!res_n) begin
            r_act_period <= DEF_PERIOD;
            r_act_frq    <= 32'd0;
            r_act_pw     <= 32'd0;
            r_act_diag   <= 32'd0;
            r_act_dly[0] <= 24'd0;
            r_act_dly[1] <= 24'd0;
            r_act_dly[2] <= 24'd0;
            r_act_dly[3] <= 24'd0;
            r_act_order  <= DEF_ORDER;
        end else if (w_copy) begin
            r_act_period <= r_sh_period;
            r_act_frq    <= r_sh_frq;
            r_act_pw     <= r_sh_pw;
            r_act_diag   <= r_sh_diag;
            r_act_dly[0] <= r_sh_dly[0];
            r_act_dly[1] <= r_sh_dly[1];
            r_act_dly[2] <= r_sh_dly[2];
            r_act_dly[3] <= r_sh_dly[3];
            r_act_order  <= r_sh_order;
        end
    end

    // External strobe: 2-FF synchronizer, falling-edge detect, one register stage before issue.
    always_ff @(posedge clk20 or negedge res_n) begin
        if (!res_n) begin
            r_ext_s1   <= 1'b1;
            r_ext_s2   <= 1'b1;
            r_ext_s2_d <= 1'b1;
            r_ext_fall <= 1'b0;
        end else begin
            r_ext_s1   <= ext_sync_n;
            r_ext_s2   <= r_ext_s1;
            r_ext_s2_d <= r_ext_s2;
            r_ext_fall <= w_ext_fall;
        end
    end

    // Period counter, registered msync_n and sync pulse counter.
    always_ff @(posedge clk20 or negedge res_n) begin
        if (!res_n) begin
            r_cnt      <= 24'd0;
            r_msync_n  <= 1'b1;
            r_sync_cnt <= 16'd0;
        end else begin
            if (w_int_mode) begin
                if (r_cnt == 24'd0) begin
                    r_cnt <= 24'd1;
                end else if (r_cnt >= w_p_last) begin
                    r_cnt <= 24'd0;
                end else begin
                    r_cnt <= r_cnt + 24'd1;
                end
            end else begin
                r_cnt <= 24'd0;
            end
            r_msync_n <= !w_pulse;
            if (w_pulse) begin
                r_sync_cnt <= r_sync_cnt + 16'd1;
            end
        end
    end

    // Read mux; shadow values are what the host sees for configuration addresses.
    always_comb begin
        w_rd_mux = 32'd0;
        case (rd_addr)
            4'd0:    w_rd_mux = {30'd0, r_ext_mode, r_run};
            4'd1:    w_rd_mux = {8'd0, r_sh_period};
            4'd2:    w_rd_mux = r_sh_frq;
            4'd3:    w_rd_mux = r_sh_pw;
            4'd4:    w_rd_mux = r_sh_diag;
            4'd5:    w_rd_mux = {8'd0, r_sh_dly[0]};
            4'd6:    w_rd_mux = {8'd0, r_sh_dly[1]};
            4'd7:    w_rd_mux = {8'd0, r_sh_dly[2]};
            4'd8:    w_rd_mux = {8'd0, r_sh_dly[3]};
            4'd9:    w_rd_mux = {24'd0, r_sh_order};
            4'd10:   w_rd_mux = {31'd0, r_commit_pend};
            4'd11:   w_rd_mux = {16'd0, r_sync_cnt};
            default: w_rd_mux = 32'd0;
        endcase
    end

    // Registered read data, one cycle latency.
    always_ff @(posedge clk20 or negedge res_n) begin
        if (!res_n) begin
            r_rd_data <= 32'd0;
        end else begin
            r_rd_data <= w_rd_mux;
        end
    end

    assign rd_data     = r_rd_data;
    assign msync_n     = r_msync_n;
    assign frq_div     = r_act_frq;
    assign pulse_w     = r_act_pw;
    assign diag_data   = r_act_diag;
    assign znd_delay0  = r_act_dly[0];
    assign znd_delay1  = r_act_dly[1];
    assign znd_delay2  = r_act_dly[2];
    assign znd_delay3  = r_act_dly[3];
    assign num_order   = r_act_order;
    assign commit_pend = r_commit_pend;

endmodule

// File: tb/tb_znd_sync_cfg.sv
// Bench for znd_sync_cfg: event-level reference model (pulse due times, shadow/active
// arrays) checked every cycle, plus directed literal checks on intervals and values.
module tb_znd_sync_cfg;

    logic        clk20 = 1'b0;
    logic        res_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = 4'd0;
    logic [31:0] wr_data = 32'd0;
    logic [3:0]  rd_addr = 4'd0;
    logic        ext_sync_n = 1'b1;
    logic [31:0] rd_data;
    logic        msync_n;
    logic [31:0] frq_div, pulse_w, diag_data;
    logic [23:0] znd_delay0, znd_delay1, znd_delay2, znd_delay3;
    logic [7:0]  num_order;
    logic        commit_pend;

    znd_sync_cfg dut (
        .clk20(clk20), .res_n(res_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .ext_sync_n(ext_sync_n), .msync_n(msync_n),
        .frq_div(frq_div), .pulse_w(pulse_w), .diag_data(diag_data),
        .znd_delay0(znd_delay0), .znd_delay1(znd_delay1), .znd_delay2(znd_delay2),
        .znd_delay3(znd_delay3), .num_order(num_order), .commit_pend(commit_pend)
    );

    always #5 clk20 = ~clk20;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    int ncyc = 0;
    int pulse_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_sh [1:9];
    logic [31:0] m_act [1:9];
    bit          m_run, m_ext, m_pend, m_was_int, m_last_ext;
    logic [15:0] m_sync;
    int          mcyc, m_next_due;
    int          due_q[$];
    logic        e_msync;
    logic [31:0] e_rd;

    initial begin
        forever begin
            @(posedge clk20 or negedge res_n);
            if (!res_n) begin
                for (int a = 1; a <= 9; a++) begin
                    m_sh[a] = 32'd0;
                end
                m_sh[1] = 32'd20000;
                m_sh[9] = 32'hE4;
                for (int a = 1; a <= 9; a++) begin
                    m_act[a] = m_sh[a];
                end
                m_run = 1'b0; m_ext = 1'b0; m_pend = 1'b0; m_was_int = 1'b0; m_last_ext = 1'b1;
                m_sync = 16'd0; mcyc = 0; m_next_due = 0; due_q.delete();
                e_msync = 1'b1; e_rd = 32'd0;
            end else begin
                bit pulse;
                bit hit;
                int keep[$];
                int pe;
                mcyc++;
                // read data reflects state before this edge
                if (rd_addr == 4'd0) e_rd = {30'd0, m_ext, m_run};
                else if (rd_addr >= 4'd1 && rd_addr <= 4'd9) e_rd = m_sh[rd_addr];
                else if (rd_addr == 4'd10) e_rd = {31'd0, m_pend};
                else if (rd_addr == 4'd11) e_rd = {16'd0, m_sync};
                else e_rd = 32'd0;
                // pulse decision: internal pulses are due times, external are scheduled 3 edges out
                hit = 1'b0;
                foreach (due_q[i]) if (due_q[i] == mcyc) hit = 1'b1;
                pulse = 1'b0;
                if (m_run && !m_ext) pulse = (!m_was_int) || (mcyc == m_next_due);
                else if (m_run && m_ext) pulse = hit;
                m_was_int = m_run && !m_ext;
                if (!ext_sync_n && m_last_ext) due_q.push_back(mcyc + 3);
                m_last_ext = ext_sync_n;
                foreach (due_q[i]) if (due_q[i] > mcyc) keep.push_back(due_q[i]);
                due_q = keep;
                if (pulse) begin
                    if (m_pend) begin
                        for (int a = 1; a <= 9; a++) m_act[a] = m_sh[a];
                        m_pend = 1'b0;
                    end
                    m_sync = m_sync + 16'd1;
                    pe = (m_act[1] < 32'd2) ? 2 : int'(m_act[1]);
                    m_next_due = mcyc + pe;
                end
                e_msync = !pulse;
                if (wr_en) begin
                    case (wr_addr)
                        4'd0: begin
                            m_run = wr_data[0];
                            m_ext = wr_data[1];
                            if (wr_data[2]) m_pend = 1'b1;
                        end
                        4'd1, 4'd5, 4'd6, 4'd7, 4'd8: m_sh[wr_addr] = wr_data & 32'h00FF_FFFF;
                        4'd2, 4'd3, 4'd4: m_sh[wr_addr] = wr_data;
                        4'd9: m_sh[9] = wr_data & 32'h0000_00FF;
                        default: ;
                    endcase
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk20);
            if (chk_en) begin
                check("msync_n", {31'd0, msync_n}, {31'd0, e_msync});
                check("rd_data", rd_data, e_rd);
                check("commit_pend", {31'd0, commit_pend}, {31'd0, m_pend});
                check("frq_div", frq_div, m_act[2]);
                check("pulse_w", pulse_w, m_act[3]);
                check("diag_data", diag_data, m_act[4]);
                check("znd_delay0", {8'd0, znd_delay0}, m_act[5]);
                check("znd_delay1", {8'd0, znd_delay1}, m_act[6]);
                check("znd_delay2", {8'd0, znd_delay2}, m_act[7]);
                check("znd_delay3", {8'd0, znd_delay3}, m_act[8]);
                check("num_order", {24'd0, num_order}, m_act[9]);
            end
        end
    end

    // pulse timestamp monitor
    initial begin
        forever begin
            @(negedge clk20);
            ncyc++;
            if (res_n && msync_n === 1'b0) pulse_q.push_back(ncyc);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk20);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_pulses(input int k, input int budget);
        int n = 0;
        while (pulse_q.size() < k && n < budget) begin
            tick();
            n++;
        end
        check("pulse_wait_timeout", {31'd0, (pulse_q.size() >= k)}, 32'd1);
    endtask

    function automatic int gap(input int i);
        if (i > 0 && i < pulse_q.size()) return pulse_q[i] - pulse_q[i-1];
        return -1;
    endfunction

    initial begin
        int n;
        bit found;
        tick();
        chk_en = 1'b1;
        tick();
        res_n = 1'b1;
        tick();
        check("rst_msync", {31'd0, msync_n}, 32'd1);
        check("rst_rd", rd_data, 32'd0);
        check("rst_pend", {31'd0, commit_pend}, 32'd0);
        check("rst_order", {24'd0, num_order}, 32'h0000_00E4);
        rd_addr = 4'd1;
        tick();
        check("rd_period_def", rd_data, 32'd20000);

        // internal mode, default period
        wr(4'd0, 32'd1);
        check("run_no_pulse_yet", {31'd0, msync_n}, 32'd1);
        tick();
        check("first_pulse", {31'd0, msync_n}, 32'd0);
        check("first_pulse_q", pulse_q.size(), 32'd1);
        wait_pulses(2, 20100);
        check("period_20000", gap(1), 32'd20000);

        // PERIOD=5 committed at the start of a period
        wr(4'd1, 32'd5);
        wr(4'd0, 32'd5);
        check("pend_set", {31'd0, commit_pend}, 32'd1);
        wait_pulses(5, 20100);
        check("old_period_completes", gap(2), 32'd20000);
        check("period_5_a", gap(3), 32'd5);
        check("period_5_b", gap(4), 32'd5);
        check("pend_cleared", {31'd0, commit_pend}, 32'd0);
        rd_addr = 4'd11;
        tick();
        tick();
        check("sync_cnt_5", rd_data, 32'd5);

        // PERIOD=0 and PERIOD=1 clamp to 2
        wr(4'd1, 32'd0);
        wr(4'd0, 32'd5);
        n = pulse_q.size();
        wait_pulses(n + 4, 100);
        check("period_0_a", gap(n + 2), 32'd2);
        check("period_0_b", gap(n + 3), 32'd2);
        rd_addr = 4'd1;
        wr(4'd1, 32'd1);
        tick();
        check("rd_period_shadow", rd_data, 32'd1);
        wr(4'd0, 32'd5);
        n = pulse_q.size();
        wait_pulses(n + 4, 100);
        check("period_1", gap(n + 3), 32'd2);

        // PERIOD=10 for the commit timing tests
        wr(4'd1, 32'd10);
        wr(4'd0, 32'd5);
        n = pulse_q.size();
        wait_pulses(n + 4, 200);
        check("period_10", gap(n + 3), 32'd10);

        // DELAY1 commit: held until the next pulse, visible in that low cycle
        wr(4'd6, 32'h0000_0123);
        wr(4'd0, 32'd5);
        check("dly1_pend", {31'd0, commit_pend}, 32'd1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (msync_n == 1'b0) found = 1'b1;
            else check("dly1_hold", {8'd0, znd_delay1}, 32'd0);
        end
        check("dly1_pulse_seen", {31'd0, found}, 32'd1);
        check("dly1_new", {8'd0, znd_delay1}, 32'h0000_0123);
        check("dly1_pend_clr", {31'd0, commit_pend}, 32'd0);

        // commit write on the pulse edge is deferred to the following pulse
        wr(4'd7, 32'h0000_0456);
        repeat (8) tick();
        wr(4'd0, 32'd5);
        check("coinc_pulse", {31'd0, msync_n}, 32'd0);
        check("coinc_not_applied", {8'd0, znd_delay2}, 32'd0);
        check("coinc_pend", {31'd0, commit_pend}, 32'd1);
        n = pulse_q.size();
        wait_pulses(n + 1, 20);
        check("coinc_gap", gap(n), 32'd10);
        check("coinc_applied", {8'd0, znd_delay2}, 32'h0000_0456);
        check("coinc_pend_clr", {31'd0, commit_pend}, 32'd0);

        // external mode
        wr(4'd0, 32'd3);
        n = pulse_q.size();
        repeat (12) tick();
        check("ext_no_int", pulse_q.size(), n);
        ext_sync_n = 1'b0;
        tick();
        check("ext_e0", {31'd0, msync_n}, 32'd1);
        tick();
        tick();
        check("ext_e2", {31'd0, msync_n}, 32'd1);
        tick();
        check("ext_pulse_lat", {31'd0, msync_n}, 32'd0);
        ext_sync_n = 1'b1;
        repeat (20) tick();
        check("ext_one_pulse", pulse_q.size(), n + 1);

        // run cleared with a commit pending, then async reset mid-cycle
        wr(4'd0, 32'd1);
        repeat (3) tick();
        wr(4'd9, 32'h0000_001B);
        wr(4'd0, 32'd4);
        n = pulse_q.size();
        repeat (15) tick();
        check("run_off_no_pulse", pulse_q.size(), n);
        check("run_off_pend", {31'd0, commit_pend}, 32'd1);
        check("run_off_order", {24'd0, num_order}, 32'h0000_00E4);
        #3;
        res_n = 1'b0;
        #1;
        check("ares_pend", {31'd0, commit_pend}, 32'd0);
        check("ares_msync", {31'd0, msync_n}, 32'd1);
        check("ares_order", {24'd0, num_order}, 32'h0000_00E4);
        check("ares_dly1", {8'd0, znd_delay1}, 32'd0);
        check("ares_rd", rd_data, 32'd0);
        tick();
        res_n = 1'b1;
        rd_addr = 4'd9;
        tick();
        tick();
        check("rd_order_shadow_reset", rd_data, 32'h0000_00E4);
        n = pulse_q.size();
        repeat (15) tick();
        check("post_reset_no_pulse", pulse_q.size(), n);
        check("post_reset_msync", {31'd0, msync_n}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
